// File: rtl/truth_table_scanner.sv
// Stimulus-and-capture engine: walks a 4-input function block through all 16
// input combinations, captures its output into a truth table and grades it.
module truth_table_scanner #(
   parameter int unsigned SETTLE   = 1,
   parameter logic [15:0] EXPECTED = 16'hAC3C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        s,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic        pass,
   output logic [4:0]  mismatch_count,
   output logic        fail_valid,
   output logic [3:0]  first_fail
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] idx_q;
   logic [3:0] cnt_q;
   logic       mismatch;
   logic       last_vec;
   logic       settle_end;

   assign mismatch   = (s != EXPECTED[idx_q]);
   assign last_vec   = (idx_q == 4'hF);
   assign settle_end = (cnt_q == SETTLE_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start)      state_d = ST_SETTLE;
         ST_SETTLE: if (settle_end) state_d = ST_SAMPLE;
         ST_SAMPLE: state_d = last_vec ? ST_DONE : ST_SETTLE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: all state below is written with non-blocking assignments so every
   // register sees pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         cnt_q          <= '0;
         table_out      <= '0;
         mismatch_count <= '0;
         fail_valid     <= 1'b0;
         first_fail     <= '0;
         pass           <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  idx_q          <= '0;
                  cnt_q          <= '0;
                  table_out      <= '0;
                  mismatch_count <= '0;
                  fail_valid     <= 1'b0;
                  first_fail     <= '0;
                  pass           <= 1'b0;
               end
            end
            ST_SETTLE: cnt_q <= cnt_q + 4'd1;
            ST_SAMPLE: begin
               table_out[idx_q] <= s;
               if (mismatch) begin
                  mismatch_count <= mismatch_count + 5'd1;
                  if (!fail_valid) begin
                     first_fail <= idx_q;
                     fail_valid <= 1'b1;
                  end
               end
               // Grade on the last vector so pass is already valid while done is high.
               if (last_vec) begin
                  pass <= (mismatch_count == 5'd0) && !mismatch;
               end else begin
                  idx_q <= idx_q + 4'd1;
                  cnt_q <= '0;
               end
            end
            ST_DONE: pass <= (mismatch_count == 5'd0);
            default: ;
         endcase
      end
   end

   // Stimulus is the index register itself, so it holds 4'hF after a scan.
   assign {a, b, c, d} = idx_q;
   assign busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized and directed bench for truth_table_scanner: two instances
// (SETTLE = 1 and 3) checked every cycle against a cycle-number based model.
module tb_truth_table_scanner;

   localparam logic [15:0] EXP = 16'hAC3C;
   localparam int S0 = 1;
   localparam int S1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        start_v [2];
   logic        rst_v   [2];
   logic [15:0] func_v  [2];
   logic        a_v [2], b_v [2], c_v [2], d_v [2], s_v [2];
   logic        busy_v [2], done_v [2], pass_v [2], fv_v [2];
   logic [15:0] tbl_v [2];
   logic [4:0]  mc_v  [2];
   logic [3:0]  ff_v  [2];

   // The function under test is a lookup in a bench-owned truth table.
   assign s_v[0] = func_v[0][{a_v[0], b_v[0], c_v[0], d_v[0]}];
   assign s_v[1] = func_v[1][{a_v[1], b_v[1], c_v[1], d_v[1]}];

   truth_table_scanner #(.SETTLE(S0), .EXPECTED(EXP)) dut0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
      .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]), .s(s_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .table_out(tbl_v[0]), .pass(pass_v[0]),
      .mismatch_count(mc_v[0]), .fail_valid(fv_v[0]), .first_fail(ff_v[0])
   );

   truth_table_scanner #(.SETTLE(S1), .EXPECTED(EXP)) dut1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
      .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]), .s(s_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .table_out(tbl_v[1]), .pass(pass_v[1]),
      .mismatch_count(mc_v[1]), .fail_valid(fv_v[1]), .first_fail(ff_v[1])
   );

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // scan_cyc = cycle number within the current scan (0 = idle); everything
   // else is derived from it with arithmetic.
   int          scan_cyc  [2] = '{0, 0};
   bit          have_scan [2] = '{1'b0, 1'b0};
   logic [15:0] mfunc     [2] = '{16'h0, 16'h0};

   function automatic int settle_of(input int i);
      return (i == 0) ? S0 : S1;
   endfunction

   function automatic int last_cyc(input int i);
      return 16 * (settle_of(i) + 1) + 1;
   endfunction

   function automatic int popc(input logic [15:0] v);
      int n = 0;
      for (int k = 0; k < 16; k++) n += int'(v[k]);
      return n;
   endfunction

   function automatic int lowest(input logic [15:0] v);
      for (int k = 0; k < 16; k++) if (v[k]) return k;
      return 0;
   endfunction

   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      for (int i = 0; i < 2; i++) begin
         if (rst_v[i]) begin
            scan_cyc[i]  <= 0;
            have_scan[i] <= 1'b0;
         end else if (scan_cyc[i] == 0) begin
            if (start_v[i]) begin
               scan_cyc[i]  <= 1;
               have_scan[i] <= 1'b1;
               mfunc[i]     <= func_v[i];
            end
         end else if (scan_cyc[i] == last_cyc(i)) begin
            scan_cyc[i] <= 0;
         end else begin
            scan_cyc[i] <= scan_cyc[i] + 1;
         end
      end
   end

   task automatic compare(input int i);
      int st, last, sc, n, stim;
      bit busy_e, done_e;
      logic [15:0] mask, diff;
      st   = settle_of(i);
      last = last_cyc(i);
      sc   = scan_cyc[i];
      if (sc == 0) begin
         busy_e = 1'b0;
         done_e = 1'b0;
         n      = have_scan[i] ? 16 : 0;
         stim   = have_scan[i] ? 15 : 0;
      end else begin
         busy_e = (sc < last);
         done_e = (sc == last);
         n      = (sc - 1) / (st + 1);   // vectors already sampled and visible
         stim   = (sc < last) ? n : 15;
      end
      mask = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
      diff = (mfunc[i] ^ EXP) & mask;
      check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(busy_e));
      check($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(done_e));
      check($sformatf("stim[%0d]", i), 32'({a_v[i], b_v[i], c_v[i], d_v[i]}), 32'(stim));
      check($sformatf("table[%0d]", i), 32'(tbl_v[i]), 32'(mfunc[i] & mask));
      check($sformatf("mcount[%0d]", i), 32'(mc_v[i]), 32'(popc(diff)));
      check($sformatf("fvalid[%0d]", i), 32'(fv_v[i]), 32'(diff != 16'h0));
      check($sformatf("ffail[%0d]", i), 32'(ff_v[i]), 32'((diff != 16'h0) ? lowest(diff) : 0));
      check($sformatf("pass[%0d]", i), 32'(pass_v[i]), 32'((n == 16) && (diff == 16'h0)));
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 2; i++) compare(i);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   // Called on a negedge with the DUT idle; returns on the negedge of cycle 1.
   task automatic launch(input int i, input logic [15:0] f, output int e0);
      func_v[i]  = f;
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
      e0 = cyc_cnt;
   endtask

   task automatic wait_done(input int i, input int e0, output int dc);
      dc = -1;
      for (int k = 0; k < 200; k++) begin
         if (done_v[i]) begin
            dc = cyc_cnt - e0 + 1;
            return;
         end
         tick();
      end
   endtask

   task automatic wait_idle(input int i);
      for (int k = 0; k < 200; k++) begin
         if (scan_cyc[i] == 0) return;
         tick();
      end
      check("idle_timeout", 32'(scan_cyc[i]), 32'd0);
   endtask

   task automatic check_results(input string tag, input int i, input logic [15:0] t,
                                input int mc, input bit fv, input int ff, input bit p);
      check({tag, "_table"}, 32'(tbl_v[i]), 32'(t));
      check({tag, "_mcount"}, 32'(mc_v[i]), 32'(mc));
      check({tag, "_fvalid"}, 32'(fv_v[i]), 32'(fv));
      if (fv) check({tag, "_ffail"}, 32'(ff_v[i]), 32'(ff));
      check({tag, "_pass"}, 32'(pass_v[i]), 32'(p));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, dc, cnt, c, n;
      int dcs [2];
      logic [15:0] tabs [2];
      bit prev_done;

      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0;
         rst_v[i]   = 1'b1;
         func_v[i]  = EXP;
      end
      repeat (3) tick();
      cmp_en = 1'b1;
      for (int i = 0; i < 2; i++) rst_v[i] = 1'b0;
      tick();

      // Reset values.
      check_results("reset", 0, 16'h0, 0, 1'b0, 0, 1'b0);
      check("reset_stim", 32'({a_v[0], b_v[0], c_v[0], d_v[0]}), 32'd0);
      check("reset_busy", 32'(busy_v[0]), 32'd0);

      // Correct function block.
      launch(0, EXP, e0);
      wait_done(0, e0, dc);
      check("good_done_cycle", 32'(dc), 32'd33);
      tick();
      check_results("good", 0, 16'hAC3C, 0, 1'b0, 0, 1'b1);

      // s stuck at 0 and stuck at 1.
      launch(0, 16'h0000, e0);
      wait_done(0, e0, dc);
      tick();
      check_results("s0", 0, 16'h0000, 8, 1'b1, 2, 1'b0);
      launch(0, 16'hFFFF, e0);
      wait_done(0, e0, dc);
      tick();
      check_results("s1", 0, 16'hFFFF, 8, 1'b1, 0, 1'b0);

      // SETTLE = 3: stimulus held 4 cycles each, busy 1..64, done at 65.
      launch(1, 16'h1234, e0);
      for (c = 1; c <= 64; c++) begin
         if (c > 1) tick();
         check($sformatf("s3_stim_c%0d", c), 32'({a_v[1], b_v[1], c_v[1], d_v[1]}), 32'((c - 1) / 4));
         check($sformatf("s3_busy_c%0d", c), 32'(busy_v[1]), 32'd1);
      end
      tick();
      check("s3_done65", 32'(done_v[1]), 32'd1);
      check("s3_busy65", 32'(busy_v[1]), 32'd0);
      tick();
      check_results("s3", 1, 16'h1234, 7, 1'b1, 3, 1'b0);

      // start pulsed in cycle 10 is ignored.
      launch(0, EXP, e0);
      cnt = 0;
      dc  = -1;
      for (c = 2; c <= 45; c++) begin
         tick();
         if (done_v[0]) begin
            cnt++;
            dc = c;
         end
         start_v[0] = (c == 10);
      end
      check("restart_done_count", 32'(cnt), 32'd1);
      check("restart_done_cycle", 32'(dc), 32'd33);

      // rst in cycle 20 aborts the scan.
      launch(0, 16'h5A5A, e0);
      for (c = 2; c <= 20; c++) tick();
      rst_v[0] = 1'b1;
      tick();
      rst_v[0] = 1'b0;
      check_results("abort", 0, 16'h0, 0, 1'b0, 0, 1'b0);
      check("abort_busy", 32'(busy_v[0]), 32'd0);
      check("abort_stim", 32'({a_v[0], b_v[0], c_v[0], d_v[0]}), 32'd0);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (done_v[0]) cnt++;
         tick();
      end
      check("abort_no_done", 32'(cnt), 32'd0);
      launch(0, EXP, e0);
      wait_done(0, e0, dc);
      check("after_abort_done_cycle", 32'(dc), 32'd33);
      tick();
      check_results("after_abort", 0, 16'hAC3C, 0, 1'b0, 0, 1'b1);

      // start held high: back-to-back scans 34 cycles apart.
      func_v[0]  = 16'h0F0F;
      start_v[0] = 1'b1;
      n = 0;
      prev_done = 1'b0;
      for (int k = 0; k < 120 && n < 3; k++) begin
         tick();
         if (prev_done) begin
            tabs[n - 1] = tbl_v[0];
            if (n == 2) begin
               start_v[0] = 1'b0;
               n = 3;
            end
         end
         if (done_v[0] && n < 2) begin
            dcs[n] = cyc_cnt;
            n++;
         end
         prev_done = done_v[0];
      end
      start_v[0] = 1'b0;
      check("b2b_scans", 32'(n), 32'd3);
      check("b2b_gap", 32'(dcs[1] - dcs[0]), 32'd34);
      check("b2b_same", 32'(tabs[1]), 32'(tabs[0]));
      check("b2b_table", 32'(tabs[0]), 32'h0F0F);
      wait_idle(0);
      tick();

      // Randomized scans with stray starts and occasional aborts.
      for (int it = 0; it < 24; it++) begin
         int i, last, rcyc;
         i    = int'($urandom_range(0, 1));
         last = last_cyc(i);
         rcyc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, last)) : -1;
         repeat ($urandom_range(0, 5)) tick();
         launch(i, 16'($urandom), e0);
         for (c = 2; c <= last + 2; c++) begin
            tick();
            start_v[i] = (scan_cyc[i] >= 1) && (scan_cyc[i] < last - 1) && ($urandom_range(0, 3) == 0);
            rst_v[i]   = (c == rcyc);
         end
         start_v[i] = 1'b0;
         rst_v[i]   = 1'b0;
         tick();
         wait_idle(i);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus-and-capture engine for a 4-input combinational function block. It drives all 16 input combinations on `a,b,c,d`, waits a programmable settle time, and samples the block's single output `s` into a 16-bit truth table. It then compares that table against an expected mask and reports pass/fail, the mismatch count and the first failing index. It sits alongside the combinational function blocks as the on-chip driver and checker of their four-input, one-output interface.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range is 1..15.
- `EXPECTED`, default 16'hAC3C: expected truth table; bit i is the expected `s` for index i = {a,b,c,d}, with a as MSB.

Ports:
- `clk` in 1: single clock; everything updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a scan; sampled only in IDLE.
- `a`, `b`, `c`, `d` out 1 each: registered stimulus, {a,b,c,d} = current index.
- `s` in 1: output of the function under test.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when results are final.
- `table_out` out 16: captured truth table; bit i = `s` sampled at index i.
- `pass` out 1: table_out == EXPECTED; valid from `done` onward.
- `mismatch_count` out 5: number of differing bits, 0..16.
- `fail_valid` out 1: at least one mismatch has been seen.
- `first_fail` out 4: lowest index that mismatched; valid when `fail_valid` = 1.

## Operation
- The FSM has four states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE -> SETTLE on `start` = 1. In the same edge:
  - idx <= 0 and {a,b,c,d} <= 0;
  - table_out, mismatch_count, fail_valid, first_fail and pass are cleared;
  - the settle counter is cleared.
- SETTLE: {a,b,c,d} holds idx. The counter increments each cycle. After exactly SETTLE cycles in this state, go to SAMPLE.
- SAMPLE (one cycle):
  - table_out[idx] <= s.
  - If s != EXPECTED[idx]: mismatch_count increments. If fail_valid = 0, set first_fail <= idx and fail_valid <= 1.
  - If idx == 15, go to DONE.
  - Otherwise idx <= idx+1, {a,b,c,d} update in the same edge, and the FSM returns to SETTLE.
- DONE (one cycle): `done` = 1, pass <= (mismatch_count == 0) including the final SAMPLE's contribution, then go to IDLE.
- Results hold unchanged in IDLE until the next accepted `start`. Stimulus outputs keep the value 4'b1111 after a scan.
- `start` is ignored in SETTLE, SAMPLE and DONE. It is not queued.
- idx is 4 bits and never wraps within a scan; termination is by the idx == 15 test.
- mismatch_count is 5 bits so that 16 mismatches is representable; it cannot overflow.

## Timing
- Reset values: state IDLE, a=b=c=d=0, busy=0, done=0, table_out=0, pass=0, mismatch_count=0, fail_valid=0, first_fail=0.
- Cycle numbering: the edge that accepts `start` is edge 0.
  - busy = 1 from cycle 1 through the final SAMPLE cycle, 16·(SETTLE+1).
  - busy = 0 in DONE.
- Each vector occupies SETTLE+1 cycles. Vector k is driven from cycle k·(SETTLE+1)+1. It is sampled in cycle (k+1)·(SETTLE+1).
- `done` is high for exactly one cycle, at cycle 16·(SETTLE+1)+1.
  - With the default SETTLE = 1 this is cycle 33.
  - With SETTLE = 3 it is cycle 65.
- `s` is sampled at the end of SAMPLE, at least SETTLE+1 edges after the stimulus changed. Combinational paths of that depth must meet that budget.
- `rst` asserted in any state takes effect at the next edge and overrides `start`:
  - the scan is aborted, no `done` is generated, and all outputs return to their reset values;
  - `start` is accepted again from the first cycle after `rst` deasserts.
- `start` held high continuously starts a new scan on the first IDLE cycle after DONE. The back-to-back scan period is 16·(SETTLE+1)+2 cycles.

## Test plan
- Correct model: use the default EXPECTED and s = f(a,b,c,d), where f is 1 at indices {2,3,4,5,10,11,13,15}. Required: table_out = 16'hAC3C, pass = 1, mismatch_count = 0, fail_valid = 0, and `done` in cycle 33.
- s tied to 0: table_out = 0, mismatch_count = 8, fail_valid = 1, first_fail = 2, pass = 0.
- s tied to 1: table_out = 16'hFFFF, mismatch_count = 8, first_fail = 0, pass = 0.
- Run with SETTLE = 3 and a stimulus monitor:
  - each {a,b,c,d} value is held for 4 cycles in order 0..15;
  - `done` occurs in cycle 65;
  - `busy` is high for cycles 1..64.
- Pulse `start` again in cycle 10 of a scan: it is ignored and `done` still occurs once, in cycle 33. Then assert `rst` in cycle 20 of a fresh scan:
  - no `done` is generated;
  - all outputs read their reset values on the next cycle;
  - a new `start` completes normally.
- Hold `start` high continuously: two consecutive scans, with `done` pulses 34 cycles apart and identical results.
